// File: rtl/breg_pkg.sv
// Shared types and helpers for the breg_mp bit register file.
// WIDTH defaults to the BITNESS macro, which falls back to 8 when the build leaves it undefined.
`ifndef BITNESS
`define BITNESS 8
`endif

package breg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } breg_clr_state_e;

   // Widest entry breg_new can carry; callers cast down to their own WIDTH.
   localparam int BREG_MAXW = 64;

   function automatic int breg_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic logic [BREG_MAXW-1:0] breg_new(input logic [BREG_MAXW-1:0] old,
                                                     input logic [BREG_MAXW-1:0] data,
                                                     input logic ovr);
      return ovr ? data : (old ^ data);
   endfunction

endpackage

// File: rtl/breg_clr_fsm.sv
// Clear sequencer for breg_mp: walks idx over every entry once, then pulses clr_done.
// Writes are blocked for the whole CLEAR/DONE window.
module breg_clr_fsm
   import breg_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = breg_aw(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_done,
   output logic          wr_ready,
   output logic [AW-1:0] clr_idx
);

   breg_clr_state_e state;
   logic [AW-1:0]   idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state <= CLEAR;
                  idx   <= '0;
               end
            end
            // idx stops on the last entry so a second pass can never start.
            CLEAR: begin
               if (idx == AW'(DEPTH-1)) state <= DONE;
               else                     idx   <= idx + AW'(1);
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign clr_busy = (state == CLEAR);
   assign clr_done = (state == DONE);
   assign wr_ready = (state == IDLE);
   assign clr_idx  = idx;

endmodule

// File: rtl/breg_mp.sv
// Multi-read-port bit register file with overwrite/XOR writes, lower-to-upper mirroring
// and a sequenced clear. Optional same-cycle write/clear forwarding: BREG_MP_BYPASS_EN.
`ifndef BITNESS
`define BITNESS 8
`endif

module breg_mp
   import breg_pkg::*;
#(
   parameter  int WIDTH  = `BITNESS,
   parameter  int DEPTH  = 16,
   parameter  int NRD    = 2,
   parameter  int MIRROR = 1,
   localparam int AW     = breg_aw(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*WIDTH-1:0] rd_data,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic                 wr_ovr,
   input  logic [AW-1:0]        wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 clr_req,
   output logic                 clr_busy,
   output logic                 clr_done
);

   logic [WIDTH-1:0] rf [DEPTH];
   logic             fire;
   logic             mir_hit;
   logic [AW-1:0]    mir_addr;
   logic [AW-1:0]    clr_idx;
   logic [WIDTH-1:0] new_val;

   breg_clr_fsm #(.DEPTH(DEPTH)) u_clr (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .wr_ready (wr_ready),
      .clr_idx  (clr_idx)
   );

   assign fire     = wr_valid & wr_ready;
   assign new_val  = WIDTH'(breg_new(BREG_MAXW'(rf[wr_addr]), BREG_MAXW'(wr_data), wr_ovr));
   // Mirror target is the same offset with the top address bit set.
   assign mir_addr = wr_addr | AW'(DEPTH/2);
   assign mir_hit  = (MIRROR != 0) && !wr_addr[AW-1];

   // Clear and write never collide: wr_ready is low for the whole clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < DEPTH; e++) rf[e] <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (clr_busy && clr_idx == AW'(e))
               rf[e] <= '0;
            else if (fire && (wr_addr == AW'(e) || (mir_hit && mir_addr == AW'(e))))
               rf[e] <= new_val;
         end
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] rv;
      assign ra = rd_addr[i*AW +: AW];
`ifdef BREG_MP_BYPASS_EN
      always_comb begin
         rv = rf[ra];
         if (fire && (ra == wr_addr || (mir_hit && ra == mir_addr))) rv = new_val;
         else if (clr_busy && ra == clr_idx)                        rv = '0;
      end
`else
      assign rv = rf[ra];
`endif
      assign rd_data[i*WIDTH +: WIDTH] = rv;
   end

endmodule

// File: tb/tb_breg_mp.sv
// Self-checking bench for breg_mp: directed scenarios plus random traffic against a
// behavioural model of the file contents and clear progress.
module tb_breg_mp;
   localparam int W  = 8;
   localparam int D  = 16;
   localparam int N  = 2;
   localparam int AW = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*AW-1:0] rd_addr;
   logic [N*W-1:0]  rd_data;
   logic           wr_valid, wr_ready, wr_ovr;
   logic [AW-1:0]  wr_addr;
   logic [W-1:0]   wr_data;
   logic           clr_req, clr_busy, clr_done;

   breg_mp #(.WIDTH(W), .DEPTH(D), .NRD(N), .MIRROR(1)) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ovr(wr_ovr),
      .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
      .clr_busy(clr_busy), .clr_done(clr_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   // Model: contents, plus clear position (-1 idle, 0..D-1 clearing that entry, D = done cycle).
   logic [W-1:0] mem [D];
   int cpos = -1;
   int busy_n, done_n;
`ifdef BREG_MP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit m_fire();
      return wr_valid && cpos == -1;
   endfunction

   function automatic logic [W-1:0] m_new();
      return wr_ovr ? wr_data : (mem[wr_addr] ^ wr_data);
   endfunction

   function automatic logic [W-1:0] m_read(input int ra);
      int wa = int'(wr_addr);
      if (BYP && m_fire() && (ra == wa || (wa < D/2 && ra == wa + D/2))) return m_new();
      if (BYP && cpos >= 0 && cpos < D && ra == cpos) return '0;
      return mem[ra];
   endfunction

   task automatic check_outputs();
      for (int p = 0; p < N; p++)
         chk($sformatf("rd_data[%0d] addr %0d", p, rd_addr[p*AW +: AW]),
             32'(rd_data[p*W +: W]), 32'(m_read(int'(rd_addr[p*AW +: AW]))));
      chk("wr_ready", 32'(wr_ready), 32'(cpos == -1));
      chk("clr_busy", 32'(clr_busy), 32'(cpos >= 0 && cpos < D));
      chk("clr_done", 32'(clr_done), 32'(cpos == D));
      busy_n += int'(clr_busy);
      done_n += int'(clr_done);
   endtask

   task automatic model_edge(input bit f, input logic [W-1:0] nv);
      int wa = int'(wr_addr);
      if (cpos >= 0 && cpos < D) begin
         mem[cpos] = '0;
         cpos++;
      end else if (cpos == D) begin
         cpos = -1;
      end else begin
         if (f) begin
            mem[wa] = nv;
            if (wa < D/2) mem[wa + D/2] = nv;
         end
         if (clr_req) cpos = 0;
      end
   endtask

   // Inputs are set at the falling edge before calling; compare, then advance one clock.
   task automatic cyc();
      bit f;
      logic [W-1:0] nv;
      #1 check_outputs();
      f  = m_fire();
      nv = m_new();
      @(posedge clk);
      model_edge(f, nv);
      @(negedge clk);
   endtask

   task automatic model_reset();
      for (int e = 0; e < D; e++) mem[e] = '0;
      cpos = -1;
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   task automatic wr(input int a, input int d, input bit ovr);
      wr_valid = 1'b1; wr_addr = AW'(a); wr_data = W'(d); wr_ovr = ovr;
   endtask

   task automatic idle();
      wr_valid = 1'b0; clr_req = 1'b0;
   endtask

   initial begin
      rst = 1'b1; idle(); wr_ovr = 1'b0; wr_addr = '0; wr_data = '0; set_rd(0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1: reset contents on both ports
      chk("reset wr_ready", 32'(wr_ready), 32'd1);
      chk("reset clr_busy", 32'(clr_busy), 32'd0);
      for (int a = 0; a < D; a++) begin
         set_rd(a, D-1-a);
         #1 chk("reset rd0", 32'(rd_data[W-1:0]), 32'd0);
         chk("reset rd1", 32'(rd_data[2*W-1:W]), 32'd0);
         cyc();
      end

      // 2: overwrite then XOR with mirror
      wr(3, 'hA5, 1'b1); cyc();
      wr(3, 'h0F, 1'b0); cyc();
      idle(); set_rd(3, 11);
      #1 chk("xor rf[3]", 32'(rd_data[W-1:0]), 32'hAA);
      chk("xor rf[11]", 32'(rd_data[2*W-1:W]), 32'hAA);
      cyc();
      wr(3, 'h00, 1'b0); cyc();
      idle(); set_rd(3, 11);
      #1 chk("xor zero keeps", 32'(rd_data[W-1:0]), 32'hAA);
      cyc();

      // 3: upper-half write leaves the lower half alone
      wr(12, 'h55, 1'b1); cyc();
      idle(); set_rd(12, 4);
      #1 chk("upper rf[12]", 32'(rd_data[W-1:0]), 32'h55);
      chk("upper rf[4]", 32'(rd_data[2*W-1:W]), 32'h00);
      cyc();

      // 4: full clear with a write held throughout
      for (int a = 0; a < D; a++) begin wr(a, a*3+1, 1'b1); cyc(); end
      idle(); clr_req = 1'b1; cyc();
      clr_req = 1'b0; wr(5, 'hFF, 1'b1);
      busy_n = 0; done_n = 0;
      repeat (D + 1) cyc();
      chk("clear busy cycles", 32'(busy_n), 32'd16);
      chk("clear done pulses", 32'(done_n), 32'd1);
      idle();
      for (int a = 0; a < D; a++) begin
         set_rd(a, a);
         #1 chk("cleared entry", 32'(rd_data[W-1:0]), 32'd0);
         cyc();
      end

      // 5: write and clear request together, then reset mid-clear
      wr(1, 'h3C, 1'b1); clr_req = 1'b1; cyc();
      idle(); set_rd(1, 9);
      #1 chk("wr before clear rf[1]", 32'(rd_data[W-1:0]), 32'h3C);
      chk("wr before clear rf[9]", 32'(rd_data[2*W-1:W]), 32'h3C);
      repeat (5) cyc();
      rst = 1'b1; model_reset();
      #1 chk("midclr rst rf[1]", 32'(rd_data[W-1:0]), 32'd0);
      chk("midclr rst rf[9]", 32'(rd_data[2*W-1:W]), 32'd0);
      chk("midclr rst clr_busy", 32'(clr_busy), 32'd0);
      @(negedge clk); rst = 1'b0;
      chk("midclr rst wr_ready", 32'(wr_ready), 32'd1);
      busy_n = 0; done_n = 0;
      for (int a = 0; a < 20; a++) begin set_rd(a % D, (a+7) % D); cyc(); end
      chk("no done after rst", 32'(done_n), 32'd0);

      // 6: same-cycle visibility of a write on both mirror ports
      wr(2, 'h11, 1'b1); cyc();
      wr(2, 'h77, 1'b1); set_rd(2, 10);
      #1 chk("fire-cycle rd0", 32'(rd_data[W-1:0]), BYP ? 32'h77 : 32'h11);
      chk("fire-cycle rd1", 32'(rd_data[2*W-1:W]), BYP ? 32'h77 : 32'h11);
      cyc();
      idle();
      #1 chk("next-cycle rd0", 32'(rd_data[W-1:0]), 32'h77);
      chk("next-cycle rd1", 32'(rd_data[2*W-1:W]), 32'h77);
      cyc();

      // Random traffic, including occasional clears
      for (int c = 0; c < 600; c++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_ovr   = 1'($urandom_range(0, 1));
         wr_addr  = AW'($urandom_range(0, D-1));
         wr_data  = W'($urandom);
         clr_req  = ($urandom_range(0, 39) == 0);
         set_rd($urandom_range(0, D-1), $urandom_range(0, D-1));
         if ($urandom_range(0, 3) == 0) set_rd(int'(wr_addr), int'(wr_addr) ^ (D/2));
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
